matrix_stream: RTL and testbench
================================

# matrix_stream

Command-driven reader for the 1024×39 lookup ROM (`matrix`). It accepts a (base, length) command, drives sequential addresses into the ROM's combinational read port, and registers the returned words into a valid/ready output stream with a last flag and an end-of-command pulse. It sits directly upstream of `matrix` on `address` and directly downstream of it on `data`, and presents ROM contents to the consuming datapath as a flow-controlled stream.

## Interface
- `ADDR_W`, 10: ROM address width; the ROM depth is 2^ADDR_W.
- `DATA_W`, 39: ROM word width.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_base`  in  ADDR_W  first ROM address.
- `cmd_len`  in  ADDR_W+1  number of words; 0 means no-op; values above 2^ADDR_W clamp to 2^ADDR_W.
- `rom_addr`  out  ADDR_W  to `matrix.address`.
- `rom_data`  in  DATA_W  from `matrix.data`; combinational in `rom_addr`.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  registered ROM word.
- `out_addr`  out  ADDR_W  address that `out_data` was read from.
- `out_last`  out  1  final word of the current command.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  single-cycle pulse at command completion.

## Operation
- The block has three states: IDLE, RUN and DRAIN. `cmd_ready` is 1 only in IDLE.
- **IDLE**
  - A handshake with `cmd_len`≠0 loads `rom_addr`←`cmd_base` and `remaining`←clamped length, then moves to RUN.
  - A handshake with `cmd_len`=0 pulses `done` on the next cycle and stays in IDLE. No beats are produced.
- **Output register load:** the register loads whenever the state is RUN and the register is free. Free means `out_valid`=0, or `out_valid`&`out_ready` in the same cycle.
  - On a load: `out_data`←`rom_data`, `out_addr`←`rom_addr`, `out_valid`←1, `out_last`←(`remaining`==1).
  - Also on a load: `rom_addr` increments and `remaining` decrements.
- **Address wrap:** `rom_addr` increments modulo 2^ADDR_W, so 1023→0 with no error.
- **RUN→DRAIN:** the state moves to DRAIN when the word with `out_last`=1 is loaded.
- **DRAIN:** no further loads occur. The handshake of the last word clears `out_valid` and `out_last`, pulses `done` on the next cycle and returns to IDLE.
- **Output not free:** if the register is full and `out_ready`=0, all outputs and the address counter hold.
- **Reset:** `rst` in any state, including mid-command, aborts the command. No `done` pulse is produced.
- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_addr`=0, `rom_addr`=0, `remaining`=0.

## Timing
- A command handshake on edge T puts `rom_addr`=base during cycle T+1.
- The first word appears with `out_valid`=1 after edge T+1.
- With `out_ready` held high, throughput is one word per cycle. An N-word command produces its last handshake N cycles after the first word is valid.
- `done` is high for exactly the one cycle after the last handshake. `cmd_ready` is 1 in that same cycle, so the next command can be accepted back-to-back.
- `out_data`, `out_addr` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- **`MATRIX_STREAM_CKSUM_EN` defined:** the block adds output `cksum` (DATA_W bits).
  - `cksum` clears on command accept.
  - On every output handshake it updates as `cksum` ^= `out_data`.
  - It holds its final value from the `done` cycle until the next accept. Its reset value is 0.
- **`MATRIX_STREAM_CKSUM_EN` undefined:** the `cksum` port and its logic are absent. All other behaviour is identical.

## Test plan
- ROM filled with mem[i]=i. Command base=5, len=4, `out_ready`=1 → `out_data` 5,6,7,8 on consecutive cycles starting at T+2. `out_last` is set only on 8, and `done` is high the cycle after.
- base=1022, len=4 → addresses 1022,1023,0,1 and data matching; `busy` drops with `done`.
- base=0, len=3, `out_ready` toggled 1,0,0,1,0,1 → each word is held stable while stalled. Exactly 3 beats occur, with no duplicates or drops.
- len=0 → no `out_valid`; `done` is high at T+1. len=2000 → exactly 1024 beats, with `out_last` on the beat where `out_addr`=base−1 mod 1024.
- `rst` asserted after the 2nd beat of a len=10 command → the next cycle shows `out_valid`=0, `busy`=0, `cmd_ready`=1, and no `done` pulse. A new command then runs normally.
- With `MATRIX_STREAM_CKSUM_EN` defined: base=1, len=3 gives `cksum`=1^2^3=0 at `done`. An immediate back-to-back command base=4, len=1 gives `cksum`=4.

Source files
------------

// File: rtl/matrix_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_stream : command-driven sequential reader for the matrix ROM,      |
// |   presenting ROM words as a registered valid/ready stream.                |
// |   Optional feature macro: MATRIX_STREAM_CKSUM_EN (adds cksum_o).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_stream #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
`ifdef MATRIX_STREAM_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   C_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                done_q, done_d;

  logic                w_cmd_hs;
  logic                w_out_hs;
  logic                w_free;
  logic                w_load;
  logic                w_final;
  logic [ADDR_W:0]     w_len_clamped;

  assign w_cmd_hs      = cmd_valid_i && (state_q == ST_IDLE);
  assign w_out_hs      = out_valid_q && out_ready_i;
  assign w_free        = !out_valid_q || out_ready_i;
  assign w_load        = (state_q == ST_RUN) && w_free;
  assign w_final       = (remaining_q == C_REM_ONE);
  assign w_len_clamped = (cmd_len_i > C_DEPTH) ? C_DEPTH : cmd_len_i;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            rom_addr_d  = cmd_base_i;
            remaining_d = w_len_clamped;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A load also retires the beat currently held, so RUN never needs
        // a separate handshake-only path.
        if (w_load) begin
          out_data_d  = rom_data_i;
          out_addr_d  = rom_addr_q;
          out_valid_d = 1'b1;
          out_last_d  = w_final;
          rom_addr_d  = rom_addr_q + C_ADDR_ONE;
          remaining_d = remaining_q - C_REM_ONE;
          if (w_final) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_out_hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

`ifdef MATRIX_STREAM_CKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (w_cmd_hs) begin
      cksum_d = '0;
    end else if (w_out_hs) begin
      cksum_d = cksum_q ^ out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum_o = cksum_q;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign rom_addr_o  = rom_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_stream : scoreboard bench for matrix_stream with an in-bench    |
// |   ROM and a per-command beat list built from (base, len) arithmetic.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_matrix_stream;
  localparam int AW    = 10;
  localparam int DW    = 39;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef MATRIX_STREAM_CKSUM_EN
  logic [DW-1:0] cksum;
`endif

  matrix_stream #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_base_i  (cmd_base),
    .cmd_len_i   (cmd_len),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
`ifdef MATRIX_STREAM_CKSUM_EN
    ,
    .cksum_o     (cksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  assign rom_data = mem[rom_addr];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] ck_q[$];
  int            total = 0;
  int            bad = 0;
  int            beats_seen = 0;
  int            ready_mode = 0;
  int            pat_i = 0;
  logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer: always ready, random, or a fixed pattern applied to valid cycles.
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (!out_valid) out_ready = 1'b1;
      else if (pat_i < 6) begin
        out_ready = pat[pat_i];
        pat_i++;
      end else out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic          exp_done, nxt_done;
    logic          chk_base, chk_first;
    logic [AW-1:0] base_exp;
    logic          prev_stall;
    logic [49:0]   held;
    beat_t         e;
    exp_done = 0; chk_base = 0; chk_first = 0; prev_stall = 0;
    base_exp = '0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 0; chk_base = 0; chk_first = 0; prev_stall = 0;
        continue;
      end
      nxt_done = 1'b0;
      chk("done", 64'(done), 64'(exp_done));
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("ready_at_done", 64'(cmd_ready), 64'd1);
`ifdef MATRIX_STREAM_CKSUM_EN
        if (ck_q.size() == 0) chk("cksum_queue", 64'd0, 64'd1);
        else chk("cksum", 64'(cksum), 64'(ck_q.pop_front()));
`endif
      end
      if (chk_first) begin
        chk("first_valid", 64'(out_valid), 64'd1);
        chk_first = 0;
      end
      if (chk_base) begin
        chk("rom_addr_base", 64'(rom_addr), 64'(base_exp));
        chk_base = 0;
        chk_first = 1;
      end
      if (prev_stall)
        chk("stall_stable", {13'd0, out_valid, out_addr, out_data, out_last},
            {13'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        beats_seen++;
        if (sb.size() == 0) chk("unexpected_beat", 64'(out_addr), 64'hFFFF);
        else begin
          e = sb.pop_front();
          chk("beat", {14'd0, out_addr, out_data, out_last}, {14'd0, e});
        end
        nxt_done = out_last;
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_len == '0) nxt_done = 1'b1;
        else begin
          chk_base = 1;
          base_exp = cmd_base;
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_addr, out_data, out_last};
      exp_done   = nxt_done;
    end
  end

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] l);
    int            n;
    logic [DW-1:0] ck;
    logic [AW-1:0] a;
    beat_t         e;
    n  = (int'(l) > DEPTH) ? DEPTH : int'(l);
    ck = '0;
    for (int i = 0; i < n; i++) begin
      a      = AW'((int'(b) + i) % DEPTH);
      e.addr = a;
      e.data = mem[a];
      e.last = (i == n - 1);
      sb.push_back(e);
      ck ^= mem[a];
    end
    ck_q.push_back(ck);
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_len   = l;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
      if (k > 5000) begin
        chk("cmd_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) break;
      if (k > 5000) begin
        chk("idle_timeout", 64'(sb.size()), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_flags", {61'd0, busy, done, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;

    issue(10'd5, 11'd4);
    wait_idle();
    issue(10'd1022, 11'd4);
    wait_idle();
    ready_mode = 2; pat_i = 0;
    issue(10'd0, 11'd3);
    wait_idle();
    ready_mode = 0;
    issue(10'd77, 11'd0);
    wait_idle();
    issue(10'd300, 11'd2000);
    wait_idle();
    issue(10'd1, 11'd3);
    issue(10'd4, 11'd1);
    wait_idle();

    beats_seen = 0;
    issue(10'd40, 11'd10);
    for (int k = 0; beats_seen < 2; k++) begin
      @(negedge clk);
      if (k > 200) begin
        chk("reset_wait_timeout", 64'(beats_seen), 64'd2);
        break;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ck_q.delete();
    @(negedge clk);
    chk("abort_flags", {60'd0, out_valid, busy, cmd_ready, done}, 64'd2);
    @(posedge clk);
    #1;
    issue(10'd600, 11'd5);
    wait_idle();

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'({$urandom(), $urandom()});
    ready_mode = 1;
    for (int c = 0; c < 30; c++) begin
      logic [AW:0] l;
      case ($urandom_range(0, 9))
        0:       l = '0;
        1:       l = AW'($urandom_range(900, 1023)) + 11'd1024;
        default: l = 11'($urandom_range(1, 24));
      endcase
      issue(AW'($urandom_range(0, DEPTH - 1)), l);
    end
    wait_idle();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
